// File: rtl/riscv_defines_pkg.sv
// Shared data-memory widths and the access-size encoding used by dmem and its arbiter.
package riscv_defines_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the dmem arbiter: req/gnt handshake plus the rvalid response.
interface dmem_arbiter_if;
    import riscv_defines_pkg::*;

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    mem_size_t             size;
    logic                  sign;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, size, sign,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, sign,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of dmem: grants one request at a time, rejects
// misaligned or out-of-range accesses, and returns one rvalid pulse per accepted request.
module dmem_arbiter
    import riscv_defines_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 4096,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output mem_size_t             mem_size,
    output logic                  mem_sign,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned SUM_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rr_last_q, rr_last_d;
    logic   owner_q, owner_d;

    logic [1:0]                 rvalid_q, rvalid_d;
    logic [1:0]                 err_q, err_d;
    logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    mem_size_t             mem_size_d;
    logic                  mem_sign_d;

    logic [1:0]            req;
    logic [1:0]            gnt_c;
    logic                  sel;
    logic                  s_we;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    mem_size_t             s_size;
    logic                  s_sign;
    logic [2:0]            s_nbytes;
    logic                  s_misal;
    logic                  s_oor;
    logic                  s_err;

    assign req = {p1.req, p0.req};

    // Winner of this cycle; round-robin favours the port that was not granted last
    always_comb begin
        sel = 1'b0;
        if (req[0] && req[1]) begin
            sel = FIXED_PRIO ? 1'b0 : ~rr_last_q;
        end else begin
            sel = req[1];
        end
    end

    always_comb begin
        s_we    = sel ? p1.we    : p0.we;
        s_addr  = sel ? p1.addr  : p0.addr;
        s_wdata = sel ? p1.wdata : p0.wdata;
        s_size  = sel ? p1.size  : p0.size;
        s_sign  = sel ? p1.sign  : p0.sign;
    end

    // Legality of the selected request; the sum is one bit wider so addresses near 2^32 cannot wrap
    always_comb begin
        s_nbytes = 3'd4;
        s_misal  = 1'b0;
        case (s_size)
            MEM_SIZE_B: s_nbytes = 3'd1;
            MEM_SIZE_H: begin
                s_nbytes = 3'd2;
                s_misal  = s_addr[0];
            end
            default: begin
                s_nbytes = 3'd4;
                s_misal  = |s_addr[1:0];
            end
        endcase
        s_oor = (SUM_W'(s_addr) + SUM_W'(s_nbytes)) > SUM_W'(MEM_BYTES);
        s_err = s_misal | s_oor;
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        gnt_c       = 2'b00;
        rvalid_d    = 2'b00;
        err_d       = 2'b00;
        rdata_d     = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_size_d  = mem_size;
        mem_sign_d  = mem_sign;

        case (state_q)
            ACCESS: begin
                state_d           = RESP;
                rvalid_d[owner_q] = 1'b1;
                if (!mem_we) begin
                    rdata_d[owner_q] = mem_rdata;
                end
            end
            default: begin
                if (|req) begin
                    gnt_c[sel] = 1'b1;
                    rr_last_d  = sel;
                    owner_d    = sel;
                    if (s_err) begin
                        // Rejected requests never reach dmem and answer one cycle early
                        state_d       = RESP;
                        rvalid_d[sel] = 1'b1;
                        err_d[sel]    = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_we_d    = s_we;
                        mem_addr_d  = s_addr;
                        mem_wdata_d = s_wdata;
                        mem_size_d  = s_size;
                        mem_sign_d  = s_sign;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            rvalid_q  <= 2'b00;
            err_q     <= 2'b00;
            rdata_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= MEM_SIZE_B;
            mem_sign  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_size  <= mem_size_d;
            mem_sign  <= mem_sign_d;
        end
    end

    // Grants are suppressed while reset is held so no request appears accepted
    assign p0.gnt    = gnt_c[0] & rst_n;
    assign p1.gnt    = gnt_c[1] & rst_n;
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.err    = err_q[0];
    assign p1.err    = err_q[1];
    assign p0.rdata  = rdata_q[0];
    assign p1.rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a byte-array dmem and a transaction-level reference.
module tb_dmem_arbiter;
    import riscv_defines_pkg::*;

    localparam int unsigned MEM_BYTES = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if u_p0 ();
    dmem_arbiter_if u_p1 ();
    dmem_arbiter_if u_f0 ();
    dmem_arbiter_if u_f1 ();

    logic        mem_we, f_mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] f_mem_addr, f_mem_wdata;
    logic [31:0] f_mem_rdata = 32'h0;
    mem_size_t   mem_size, f_mem_size;
    logic        mem_sign, f_mem_sign;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .p0(u_p0), .p1(u_p1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .p0(u_f0), .p1(u_f1),
        .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_size(f_mem_size), .mem_sign(f_mem_sign), .mem_rdata(f_mem_rdata)
    );

    int checks = 0;
    int failures = 0;
    int exp_writes = 0;

    function automatic int nbytes(input mem_size_t s);
        return (s == MEM_SIZE_B) ? 1 : (s == MEM_SIZE_H) ? 2 : 4;
    endfunction

    // dmem stand-in: combinational read with extension, write on the clock edge
    logic [7:0] dmem [MEM_BYTES];
    logic       mem_clear = 1'b1;
    int         wr_count;

    always_comb begin
        int          rd_nb;
        logic [31:0] idx;
        rd_nb = nbytes(mem_size);
        mem_rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            idx = (mem_addr + 32'(k)) % 32'(MEM_BYTES);
            if (k < rd_nb) mem_rdata[8*k +: 8] = dmem[idx];
        end
        if (mem_sign && rd_nb == 1 && mem_rdata[7])  mem_rdata[31:8]  = 24'hFFFFFF;
        if (mem_sign && rd_nb == 2 && mem_rdata[15]) mem_rdata[31:16] = 16'hFFFF;
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) dmem[i] <= 8'h00;
            wr_count <= 0;
        end else if (mem_we) begin
            for (int k = 0; k < nbytes(mem_size); k++)
                dmem[(mem_addr + 32'(k)) % 32'(MEM_BYTES)] <= mem_wdata[8*k +: 8];
            wr_count <= wr_count + 1;
        end
    end

    // Reference memory, updated once per accepted legal store
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic logic pred_err(input logic [31:0] a, input mem_size_t s);
        logic mis;
        mis = (s == MEM_SIZE_H && a[0]) || (s == MEM_SIZE_W && a[1:0] != 2'b00);
        return mis || (longint'(a) + longint'(nbytes(s)) > longint'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input mem_size_t s, input logic sg);
        longint v;
        int     nb;
        v  = 0;
        nb = nbytes(s);
        for (int k = 0; k < nb; k++) v += longint'(ref_mem[a + 32'(k)]) << (8 * k);
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 1) ? u_p1.gnt : u_p0.gnt;
    endfunction
    function automatic logic rvalid_of(input int p);
        return (p == 1) ? u_p1.rvalid : u_p0.rvalid;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 1) ? u_p1.err : u_p0.err;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? u_p1.rdata : u_p0.rdata;
    endfunction

    task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input mem_size_t s, input logic sg);
        if (p == 1) begin
            u_p1.req = r; u_p1.we = we; u_p1.addr = a; u_p1.wdata = wd; u_p1.size = s; u_p1.sign = sg;
        end else begin
            u_p0.req = r; u_p0.we = we; u_p0.addr = a; u_p0.wdata = wd; u_p0.size = s; u_p0.sign = sg;
        end
    endtask

    // One request on one port, checked for grant, dmem issue, and response timing/content
    task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input mem_size_t size, input logic sign);
        logic        exp_err, got;
        logic [31:0] exp_data;
        int          cyc;
        exp_err  = pred_err(addr, size);
        exp_data = (!we && !exp_err) ? ref_load(addr, size, sign) : 32'h0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, addr, wdata, size, sign);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = gnt_of(p);
        end
        check("gnt_latency", 32'(cyc), 32'd1);
        check("gnt_other", 32'(gnt_of(1 - p)), 32'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, MEM_SIZE_B, 1'b0);
        if (!got) return;
        if (exp_err) begin
            @(negedge clk);
            check("err_rvalid", 32'(rvalid_of(p)), 32'd1);
            check("err_flag", 32'(err_of(p)), 32'd1);
            check("err_rdata", rdata_of(p), 32'h0);
            check("err_mem_we", 32'(mem_we), 32'd0);
        end else begin
            @(negedge clk);
            check("acc_rvalid", 32'(rvalid_of(p)), 32'd0);
            check("acc_mem_we", 32'(mem_we), 32'(we));
            check("acc_mem_addr", mem_addr, addr);
            check("acc_mem_size", 32'(mem_size), 32'(size));
            if (we) check("acc_mem_wdata", mem_wdata, wdata);
            @(negedge clk);
            check("rsp_rvalid", 32'(rvalid_of(p)), 32'd1);
            check("rsp_other_rvalid", 32'(rvalid_of(1 - p)), 32'd0);
            check("rsp_err", 32'(err_of(p)), 32'd0);
            check("rsp_rdata", rdata_of(p), exp_data);
            check("rsp_mem_we", 32'(mem_we), 32'd0);
            if (we) begin
                for (int k = 0; k < nbytes(size); k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
                exp_writes++;
            end
        end
    endtask

    // Both ports of both DUTs keep requesting until each has had four grants
    task automatic arb_test();
        int seq_r [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int seq_f [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int rem_r [2] = '{4, 4};
        int rem_f [2] = '{4, 4};
        int nr = 0, nf = 0, last_r = -2, gp;
        u_p0.we = 1'b0; u_p0.addr = 32'h0; u_p0.size = MEM_SIZE_W; u_p0.sign = 1'b0; u_p0.wdata = 32'h0;
        u_p1.we = 1'b0; u_p1.addr = 32'h4; u_p1.size = MEM_SIZE_W; u_p1.sign = 1'b0; u_p1.wdata = 32'h0;
        u_f0.we = 1'b0; u_f0.addr = 32'h0; u_f0.size = MEM_SIZE_W; u_f0.sign = 1'b0; u_f0.wdata = 32'h0;
        u_f1.we = 1'b0; u_f1.addr = 32'h4; u_f1.size = MEM_SIZE_W; u_f1.sign = 1'b0; u_f1.wdata = 32'h0;
        @(posedge clk); #1;
        u_p0.req = 1'b1; u_p1.req = 1'b1; u_f0.req = 1'b1; u_f1.req = 1'b1;
        for (int cyc = 0; cyc < 80 && (nr < 8 || nf < 8); cyc++) begin
            @(negedge clk);
            if (u_p0.gnt && u_p1.gnt) check("arb_rr_exclusive", 32'd1, 32'd0);
            if (u_f0.gnt && u_f1.gnt) check("arb_fp_exclusive", 32'd1, 32'd0);
            if (u_p0.gnt || u_p1.gnt) begin
                gp = u_p1.gnt ? 1 : 0;
                if (nr < 8) check("arb_rr_order", 32'(gp), 32'(seq_r[nr]));
                if (nr > 0) check("arb_rr_spacing", 32'(cyc - last_r), 32'd2);
                last_r = cyc;
                nr++;
                rem_r[gp]--;
            end
            if (u_f0.gnt || u_f1.gnt) begin
                gp = u_f1.gnt ? 1 : 0;
                if (nf < 8) check("arb_fp_order", 32'(gp), 32'(seq_f[nf]));
                nf++;
                rem_f[gp]--;
            end
            @(posedge clk); #1;
            u_p0.req = rem_r[0] > 0; u_p1.req = rem_r[1] > 0;
            u_f0.req = rem_f[0] > 0; u_f1.req = rem_f[1] > 0;
        end
        check("arb_rr_count", 32'(nr), 32'd8);
        check("arb_fp_count", 32'(nf), 32'd8);
        repeat (3) @(posedge clk);
    endtask

    // Reset during the ACCESS cycle of a store must drop it and clear all outputs at once
    task automatic reset_test();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h40, 32'h1234, MEM_SIZE_W, 1'b0);
        @(negedge clk);
        check("rst_setup_gnt", 32'(u_p0.gnt), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, MEM_SIZE_B, 1'b0);
        check("rst_setup_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rvalid", 32'(u_p0.rvalid), 32'd0);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, MEM_SIZE_W, 1'b0);
        #1;
        check("rst_gnt_held", 32'(u_p1.gnt), 32'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, MEM_SIZE_B, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_no_write", 32'(wr_count), 32'(exp_writes));
        do_txn(0, 1'b0, 32'h40, 32'h0, MEM_SIZE_W, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        mem_size_t   sz;
        int          r;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, MEM_SIZE_B, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, MEM_SIZE_B, 1'b0);
        u_f0.req = 1'b0; u_f0.we = 1'b0; u_f0.addr = 32'h0; u_f0.wdata = 32'h0; u_f0.size = MEM_SIZE_B; u_f0.sign = 1'b0;
        u_f1.req = 1'b0; u_f1.we = 1'b0; u_f1.addr = 32'h0; u_f1.wdata = 32'h0; u_f1.size = MEM_SIZE_B; u_f1.sign = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_rvalid", 32'({u_p1.rvalid, u_p0.rvalid}), 32'd0);
        check("reset_gnt", 32'({u_p1.gnt, u_p0.gnt}), 32'd0);

        arb_test();
        reset_test();

        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, MEM_SIZE_W, 1'b0);
        do_txn(0, 1'b0, 32'h10, 32'h0, MEM_SIZE_W, 1'b0);
        do_txn(0, 1'b1, 32'h21, 32'h80, MEM_SIZE_B, 1'b0);
        do_txn(1, 1'b0, 32'h21, 32'h0, MEM_SIZE_B, 1'b1);
        do_txn(1, 1'b0, 32'h21, 32'h0, MEM_SIZE_B, 1'b0);
        do_txn(1, 1'b0, 32'h3, 32'h0, MEM_SIZE_H, 1'b0);
        do_txn(1, 1'b0, 32'h102, 32'h0, MEM_SIZE_W, 1'b0);
        do_txn(0, 1'b1, 32'(MEM_BYTES - 2), 32'h55AA55AA, MEM_SIZE_W, 1'b0);
        do_txn(0, 1'b1, 32'(MEM_BYTES - 4), 32'hCAFEF00D, MEM_SIZE_W, 1'b0);
        do_txn(1, 1'b0, 32'(MEM_BYTES - 4), 32'h0, MEM_SIZE_W, 1'b0);
        check("directed_writes", 32'(wr_count), 32'(exp_writes));

        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 2);
            sz = (r == 0) ? MEM_SIZE_B : (r == 1) ? MEM_SIZE_H : MEM_SIZE_W;
            r  = $urandom_range(0, 9);
            if (r < 6)      addr = 32'($urandom_range(0, 63));
            else if (r < 9) addr = 32'(MEM_BYTES - 8 + $urandom_range(0, 11));
            else            addr = $urandom;
            do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), addr, $urandom, sz,
                   1'($urandom_range(0, 1)));
        end
        check("total_writes", 32'(wr_count), 32'(exp_writes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
